add_round_key: RTL and testbench
================================

// Module: add_round_key
// PURPOSE
// - AES AddRoundKey stage: bytewise XOR of the 4x4 state with the 4x4 round key.
// - Sits in the round datapath after ShiftRows (or MixColumns) and before the next round's SubBytes.
// - Output is registered, one clock latency, with a valid strobe carried alongside the data.
// PARAMETERS
// - OUT_REG      default 1  1 = registered output (latency 1); 0 = combinational data, out_valid = in_valid
// - BYTE_W       default 8  byte width; fixed at 8 for AES, any other value is unsupported
// PORTS
// - clk             in   1          single clock; all state updates on rising edge
// - reset           in   1          synchronous, active-high reset
// - in_valid        in   1          shiftrowsout/roundkey are valid this cycle
// - shiftrowsout    in   8 [3:0][3:0]  state bytes, index [row][col]
// - roundkey        in   8 [3:0][3:0]  round-key bytes, index [row][col]
// - out_valid       out  1          addroundkeyout holds a valid result
// - addroundkeyout  out  8 [3:0][3:0]  result bytes, index [row][col]
// BEHAVIOUR
// - Function: addroundkeyout[r][c] = shiftrowsout[r][c] ^ roundkey[r][c] for all r,c in 0..3.
// - The 16 bytes are independent; there is no carry and no cross-byte mixing; widths stay 8 bits.
// - Reset (OUT_REG=1): on a clock edge with reset=1, all 16 output bytes become 8'h00 and out_valid becomes 0.
// - Normal operation (OUT_REG=1): on each rising edge with reset=0:
//   - out_valid <= in_valid.
//   - When in_valid=1, every byte of addroundkeyout is loaded with the XOR.
//   - When in_valid=0, addroundkeyout holds its previous value; there are no spurious updates.
// - Latency is exactly 1 cycle; throughput is 1 block per cycle; there is no backpressure and no ready signal.
// - Back-to-back valids: each cycle's result appears on the following cycle, with no bubbles.
// - Reset mid-stream: reset wins over in_valid on the same edge. The first valid after reset deasserts
//   produces out_valid on the next edge.
// - OUT_REG=0: addroundkeyout is combinational XOR (ignores in_valid), out_valid = in_valid & ~reset;
//   clk is unused except through reset gating.
// - Identities the implementation must satisfy:
//   - XOR with an all-zero key passes the state through unchanged.
//   - XOR of identical state and key yields all-zero output.
// - No X propagation from unused paths. Outputs are defined from the first clock edge with reset=1.
// STRUCTURE
// - Shared package aes_pkg:
//   - byte_t (logic [7:0]), state_t (byte_t [3:0][3:0]), AES_NB=4.
//   - Reused by subbytes, shiftrows, mixcolumns and the key schedule.
// - One sub-module, ark_column_xor: XOR of one 4-byte column (combinational), instantiated 4x via
//   generate over col.
// - The top level holds the generate loop, the output register bank, the valid flop and the OUT_REG mux.
// TESTING
// - Reset check: assert reset for 2 cycles with random inputs and in_valid=1.
//   -> out_valid=0 and all output bytes are 8'h00.
// - Single-byte vectors, in_valid=1, all other bytes 0, one cycle later:
//   - [3][3]: 28 ^ 74 -> 86 (8'h56).
//   - [2][2]: 6 ^ 127 -> 121 (8'h79).
//   - [1][1]: 195 ^ 13 -> 206 (8'hCE).
// - FIPS-197 round 0:
//   - Inputs: state 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f (column-major).
//   - Expected: 00102030405060708090a0b0c0d0e0f0.
// - Hold and stream:
//   - Drive valid blocks A, B, C back-to-back, then in_valid=0 for 3 cycles.
//   - -> Results A^k, B^k, C^k on consecutive cycles; the output stays at C^k with out_valid=0.
// - Identities: key=0 -> output equals state; key=state -> output all zero; state=8'hFF all, key=8'h0F all -> 8'hF0 all.
// - Reset mid-stream: assert reset together with in_valid=1.
//   -> The next edge gives out_valid=0 and the outputs are zero; the first post-reset valid appears 1 cycle later.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath types.
// SubBytes, ShiftRows, MixColumns, AddRoundKey and the key schedule all use
// these types so that a state or key word can move between stages unchanged.
package aes_pkg;

  // Number of 32-bit columns in the AES state.
  localparam int AES_NB = 4;

  // One AES byte.
  typedef logic [7:0] byte_t;

  // The full 128-bit state, indexed [row][col].
  // state[3][3] occupies the most significant byte of the packed vector.
  typedef byte_t [AES_NB-1:0][AES_NB-1:0] state_t;

endpackage

// File: rtl/ark_column_xor.sv
// XOR of one 4-byte AES column with the matching round-key column.
// The bytes are independent of one another: there is no carry and no
// cross-byte mixing.
module ark_column_xor
  import aes_pkg::*;
(
  input  byte_t [AES_NB-1:0] i_stateCol,
  input  byte_t [AES_NB-1:0] i_keyCol,
  output byte_t [AES_NB-1:0] o_sumCol
);

  // Combine each byte of the column with its key byte.
  always_comb begin
    o_sumCol = '0;
    for (int row = 0; row < AES_NB; row++) begin
      o_sumCol[row] = i_stateCol[row] ^ i_keyCol[row];
    end
  end

endmodule

// File: rtl/add_round_key.sv
// AES AddRoundKey stage.
// Computes the bytewise XOR of the state with the round key.
// OUT_REG=1 registers the result and its valid strobe, giving one cycle of
// latency. OUT_REG=0 passes the XOR straight through.
// BYTE_W documents the byte width and must stay at 8.
module add_round_key
  import aes_pkg::*;
#(
  parameter int OUT_REG = 1,
  parameter int BYTE_W  = 8
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   in_valid,
  input  state_t shiftrowsout,
  input  state_t roundkey,
  output logic   out_valid,
  output state_t addroundkeyout
);

  // The datapath is built from byte_t, so only 8-bit bytes are supported.
  if (BYTE_W != 8) begin : gBadByteWidth
    $error("add_round_key: BYTE_W must be 8");
  end

  // Columns are regrouped [col][row] so that each column is one contiguous slice.
  byte_t [AES_NB-1:0][AES_NB-1:0] w_stateCols;
  byte_t [AES_NB-1:0][AES_NB-1:0] w_keyCols;
  byte_t [AES_NB-1:0][AES_NB-1:0] w_sumCols;
  state_t                         w_xorState;

  for (genvar col = 0; col < AES_NB; col++) begin : gColumn
    for (genvar row = 0; row < AES_NB; row++) begin : gRow
      assign w_stateCols[col][row] = shiftrowsout[row][col];
      assign w_keyCols[col][row]   = roundkey[row][col];
      assign w_xorState[row][col]  = w_sumCols[col][row];
    end

    ark_column_xor uColumnXor (
      .i_stateCol (w_stateCols[col]),
      .i_keyCol   (w_keyCols[col]),
      .o_sumCol   (w_sumCols[col])
    );
  end

  if (OUT_REG != 0) begin : gRegistered
    state_t r_data;
    logic   r_valid;

    // Load the XOR only for valid input, so idle cycles keep the last result visible.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= in_valid;
        if (in_valid) begin
          r_data <= w_xorState;
        end
      end
    end

    assign addroundkeyout = r_data;
    assign out_valid      = r_valid;
  end else begin : gCombinational
    assign addroundkeyout = w_xorState;
    assign out_valid      = in_valid & ~reset;
  end

endmodule

// File: tb/tb_add_round_key.sv
// Directed testbench for add_round_key with the default registered output.
// Vectors are written as 128-bit column-major strings in FIPS-197 order and
// converted into [row][col] state arrays.
module tb_add_round_key;
  import aes_pkg::*;

  logic   clk;
  logic   reset;
  logic   inValid;
  state_t stateIn;
  state_t keyIn;
  logic   outValid;
  state_t dataOut;

  int errorCount = 0;
  int checkCount = 0;

  typedef struct {
    string       name;
    logic [127:0] stateVec;
    logic [127:0] keyVec;
    logic [127:0] expVec;
  } vector_t;

  add_round_key dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (inValid),
    .shiftrowsout   (stateIn),
    .roundkey       (keyIn),
    .out_valid      (outValid),
    .addroundkeyout (dataOut)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte k of the column-major string goes to row k%4, column k/4.
  function automatic state_t toState(input logic [127:0] v);
    state_t s;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        s[r][c] = v[127 - 8*(r + 4*c) -: 8];
      end
    end
    return s;
  endfunction

  // Drive the inputs away from the active edge, then let one rising edge pass.
  task automatic applyStimulus(input logic rst, input logic valid,
                               input logic [127:0] sv, input logic [127:0] kv);
    @(negedge clk);
    reset   = rst;
    inValid = valid;
    stateIn = toState(sv);
    keyIn   = toState(kv);
    @(posedge clk);
    #1;
  endtask

  // Compare the valid strobe and the data bank against expected values.
  task automatic checkOutput(input string name, input logic expValid,
                             input logic [127:0] expVec);
    state_t expState;
    expState = toState(expVec);
    checkCount++;
    if (outValid !== expValid) begin
      errorCount++;
      $display("[TB] FAIL %s valid: got %0b expected %0b", name, outValid, expValid);
    end
    checkCount++;
    if (dataOut !== expState) begin
      errorCount++;
      $display("[TB] FAIL %s data: got %h expected %h", name, dataOut, expState);
    end
  endtask

  localparam logic [127:0] KEY_S = 128'hffffffff_00000000_ffffffff_00000000;
  localparam logic [127:0] BLK_A = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [127:0] BLK_B = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] BLK_C = 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
  localparam logic [127:0] EXP_A = 128'hfedcba98_89abcdef_01234567_76543210;
  localparam logic [127:0] EXP_B = 128'heeeeeeee_22222222_cccccccc_44444444;
  localparam logic [127:0] EXP_C = 128'h5a5a5a5a_5a5a5a5a_f0f0f0f0_f0f0f0f0;
  localparam logic [127:0] FIPS_KEY = 128'h00010203_04050607_08090a0b_0c0d0e0f;

  vector_t vectors[7];

  initial begin
    vectors[0] = '{"byte33", 128'h0000001c, 128'h0000004a, 128'h00000056};
    vectors[1] = '{"byte22", 128'h00000000_00000000_00000600_00000000,
                             128'h00000000_00000000_00007f00_00000000,
                             128'h00000000_00000000_00007900_00000000};
    vectors[2] = '{"byte11", 128'h00000000_00c30000_00000000_00000000,
                             128'h00000000_000d0000_00000000_00000000,
                             128'h00000000_00ce0000_00000000_00000000};
    vectors[3] = '{"fips_round0", 128'h00112233_44556677_8899aabb_ccddeeff,
                                  FIPS_KEY,
                                  128'h00102030_40506070_8090a0b0_c0d0e0f0};
    vectors[4] = '{"zero_key", BLK_B, 128'h0, BLK_B};
    vectors[5] = '{"key_eq_state", BLK_A, BLK_A, 128'h0};
    vectors[6] = '{"ff_xor_0f", {16{8'hff}}, {16{8'h0f}}, {16{8'hf0}}};

    reset   = 1'b1;
    inValid = 1'b1;
    stateIn = '0;
    keyIn   = '0;

    // Two reset cycles with random valid data must still clear everything.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1,
                    {$urandom(), $urandom(), $urandom(), $urandom()},
                    {$urandom(), $urandom(), $urandom(), $urandom()});
      checkOutput($sformatf("reset%0d", i), 1'b0, 128'h0);
    end

    // Single-cycle vectors, each result one edge after its inputs.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, vectors[i].stateVec, vectors[i].keyVec);
      checkOutput(vectors[i].name, 1'b1, vectors[i].expVec);
    end

    // Back-to-back blocks with no bubbles.
    applyStimulus(1'b0, 1'b1, BLK_A, KEY_S);
    checkOutput("stream_a", 1'b1, EXP_A);
    applyStimulus(1'b0, 1'b1, BLK_B, KEY_S);
    checkOutput("stream_b", 1'b1, EXP_B);
    applyStimulus(1'b0, 1'b1, BLK_C, KEY_S);
    checkOutput("stream_c", 1'b1, EXP_C);

    // Idle cycles with changing inputs must leave the last result in place.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, BLK_A ^ {4{$urandom()}}, {4{$urandom()}});
      checkOutput($sformatf("hold%0d", i), 1'b0, EXP_C);
    end

    // Reset arriving together with valid data wins.
    applyStimulus(1'b1, 1'b1, BLK_B, KEY_S);
    checkOutput("midreset", 1'b0, 128'h0);

    // First valid after reset appears one edge later.
    applyStimulus(1'b0, 1'b1, 128'h0, FIPS_KEY);
    checkOutput("post_reset", 1'b1, FIPS_KEY);

    applyStimulus(1'b0, 1'b0, BLK_C, KEY_S);
    checkOutput("post_reset_idle", 1'b0, FIPS_KEY);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
